// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load/branch/mul-div stalls, redirect flush
// Optional mul/div occupancy tracking enabled by defining HAZARD_MULDIV_EN.
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeregE,
  input  logic [4:0]  writeregM,
  input  logic [4:0]  writeregW,
  input  logic        regwriteE,
  input  logic        regwriteM,
  input  logic        regwriteW,
  input  logic        memtoregE,
  input  logic        memtoregM,
  input  logic        branchD,
  input  logic        jumpD,
  input  logic        pcsrcD,
  input  logic        mdstartD,
  input  logic        mdstartE,
  input  logic        mdreadD,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        forwardAD,
  output logic        forwardBD,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        mdbusy,
  output logic [15:0] stallcnt
);

  logic lwstall, branchstall, mdstall, stall;
  logic hitE_d, hitM_d;

`ifdef HAZARD_MULDIV_EN
  typedef enum logic {IDLE, BUSY} md_state_t;
  localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

  md_state_t  state, state_next;
  logic [7:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (mdstartE) begin
        state_next = BUSY;
        cnt_next   = MD_LOAD;
      end
      BUSY: begin
        // a new mdstartE while busy is dropped, the unit is not pipelined
        if (cnt == 8'd0) state_next = IDLE;
        else             cnt_next   = cnt - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mdbusy  = (state == BUSY) & ~reset;
  assign mdstall = mdbusy & (mdreadD | mdstartD);
`else
  logic unused_md;
  assign unused_md = ^{mdstartD, mdstartE, mdreadD};
  assign mdbusy    = 1'b0;
  assign mdstall   = 1'b0;
`endif

  assign hitE_d = (writeregE != 5'd0) & ((writeregE == rsD) | (writeregE == rtD));
  assign hitM_d = (writeregM != 5'd0) & ((writeregM == rsD) | (writeregM == rtD));

  assign lwstall     = memtoregE & hitE_d;
  assign branchstall = branchD & ((regwriteE & hitE_d) | (memtoregM & hitM_d));
  assign stall       = (lwstall | branchstall | mdstall) & ~reset;

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rsE != 5'd0 && regwriteM && writeregM == rsE)      forwardAE = 2'b10;
    else if (rsE != 5'd0 && regwriteW && writeregW == rsE) forwardAE = 2'b01;
    if (rtE != 5'd0 && regwriteM && writeregM == rtE)      forwardBE = 2'b10;
    else if (rtE != 5'd0 && regwriteW && writeregW == rtE) forwardBE = 2'b01;
    forwardAD = (rsD != 5'd0) & regwriteM & (writeregM == rsD);
    forwardBD = (rtD != 5'd0) & regwriteM & (writeregM == rtD);
    if (reset) begin
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
    end
  end

  // a stalled redirect must not squash the instruction it is waiting on
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall | reset;
  assign flushD = ((pcsrcD | jumpD) & ~stall) | reset;

  always_ff @(posedge clk) begin
    if (reset)                            stallcnt <= 16'd0;
    else if (stall && stallcnt != 16'hFFFF) stallcnt <= stallcnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven and sequence checks for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, jumpD, pcsrcD, mdstartD, mdstartE, mdreadD;
  logic stallF, stallD, flushD, flushE, forwardAD, forwardBD, mdbusy;
  logic [1:0] forwardAE, forwardBE;
  logic [15:0] stallcnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD),
    .mdstartD(mdstartD), .mdstartE(mdstartE), .mdreadD(mdreadD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdbusy(mdbusy), .stallcnt(stallcnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, mr_e, mr_m, br, jmp, pcs;
    logic       x_stall, x_flushd;
    logic [1:0] x_fae, x_fbe;
    logic       x_fad, x_fbd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, jumpD, pcsrcD, mdstartD, mdstartE, mdreadD} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lw();
    memtoregE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
  endtask

  initial begin
    //          name      rsD rtD rsE rtE wrE wrM wrW rwE rwM rwW mrE mrM br jmp pcs stall flD fAE    fBE    fAD fBD
    vecs[0]  = '{"fwd_m_prio", 0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0};
    vecs[1]  = '{"fwd_rs0",    0, 0, 0, 0, 0, 5, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[2]  = '{"fwd_w",      0, 0, 7, 7, 0, 7, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0};
    vecs[3]  = '{"fwd_bm",     0, 0, 1, 9, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0};
    vecs[4]  = '{"fwd_dec",    4, 4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1};
    vecs[5]  = '{"lwstall",    0, 8, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0};
    vecs[6]  = '{"lw_r0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[7]  = '{"pcsrc_fl",   1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0};
    vecs[8]  = '{"br_stallE",  3, 2, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0};
    vecs[9]  = '{"jump_fl",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0};
    vecs[10] = '{"br_stallM",  1, 6, 0, 0, 0, 6, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0};
    vecs[11] = '{"br_r0",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
    vecs[12] = '{"fwd_nowr",   0, 0, 5, 5, 0, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};

    clr();
    reset = 1'b1;
    rsE = 5'd5; writeregM = 5'd5; regwriteM = 1'b1; rsD = 5'd5;
    memtoregE = 1'b1; writeregE = 5'd5;
    @(negedge clk);
    chk("rst_stallF", stallF, 0);
    chk("rst_stallD", stallD, 0);
    chk("rst_flushD", flushD, 1);
    chk("rst_flushE", flushE, 1);
    chk("rst_fAE", forwardAE, 0);
    chk("rst_fAD", forwardAD, 0);
    chk("rst_mdbusy", mdbusy, 0);
    step();
    chk("rst_stallcnt", stallcnt, 0);
    reset = 1'b0;
    clr();

    for (int i = 0; i < 13; i++) begin
      rsD = vecs[i].rs_d; rtD = vecs[i].rt_d; rsE = vecs[i].rs_e; rtE = vecs[i].rt_e;
      writeregE = vecs[i].wr_e; writeregM = vecs[i].wr_m; writeregW = vecs[i].wr_w;
      regwriteE = vecs[i].rw_e; regwriteM = vecs[i].rw_m; regwriteW = vecs[i].rw_w;
      memtoregE = vecs[i].mr_e; memtoregM = vecs[i].mr_m;
      branchD = vecs[i].br; jumpD = vecs[i].jmp; pcsrcD = vecs[i].pcs;
      #1;
      chk({vecs[i].name, "_stallF"}, stallF, vecs[i].x_stall);
      chk({vecs[i].name, "_stallD"}, stallD, vecs[i].x_stall);
      chk({vecs[i].name, "_flushE"}, flushE, vecs[i].x_stall);
      chk({vecs[i].name, "_flushD"}, flushD, vecs[i].x_flushd);
      chk({vecs[i].name, "_fAE"}, forwardAE, vecs[i].x_fae);
      chk({vecs[i].name, "_fBE"}, forwardBE, vecs[i].x_fbe);
      chk({vecs[i].name, "_fAD"}, forwardAD, vecs[i].x_fad);
      chk({vecs[i].name, "_fBD"}, forwardBD, vecs[i].x_fbd);
    end

    // stall counter: fresh reset, then three load-use stall edges
    clr();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_lw();
    repeat (3) step();
    chk("stallcnt_3", stallcnt, 3);
    clr();
    step();
    chk("stallcnt_hold", stallcnt, 3);

`ifdef HAZARD_MULDIV_EN
    mdstartE = 1'b1;
    step();
    mdstartE = 1'b0;
    mdreadD  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("md_busy_c%0d", i + 1), mdbusy, 1);
      chk($sformatf("md_stall_c%0d", i + 1), stallF, 1);
      step();
    end
    chk("md_busy_c5", mdbusy, 0);
    chk("md_stall_c5", stallF, 0);
    chk("md_stallcnt", stallcnt, 7);
    mdreadD = 1'b0;

    mdstartE = 1'b1;
    step();
    mdstartE = 1'b0;
    step();
    chk("md_busy_cnt2", mdbusy, 1);
    reset = 1'b1;
    #1;
    chk("mdrst_busy", mdbusy, 0);
    chk("mdrst_flushD", flushD, 1);
    chk("mdrst_flushE", flushE, 1);
    step();
    reset = 1'b0;
    mdreadD = 1'b1;
    #1;
    chk("mdrst_busy_after", mdbusy, 0);
    chk("mdrst_nostall", stallF, 0);
    chk("mdrst_stallcnt", stallcnt, 0);
    step();
    chk("mdrst_busy_after2", mdbusy, 0);
    mdreadD = 1'b0;
`else
    mdstartE = 1'b1;
    step();
    mdstartE = 1'b0;
    mdreadD  = 1'b1;
    mdstartD = 1'b1;
    #1;
    chk("nomd_busy", mdbusy, 0);
    chk("nomd_stall", stallF, 0);
    step();
    chk("nomd_busy2", mdbusy, 0);
    mdreadD  = 1'b0;
    mdstartD = 1'b0;
`endif

    // saturation: reset, then 65535 + 300 stall edges
    clr();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_lw();
    repeat (65535) step();
    chk("sat_reach", stallcnt, 16'hFFFF);
    repeat (300) step();
    chk("sat_hold", stallcnt, 16'hFFFF);
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
